// File: rtl/ds_width_multiplier.sv
// Upsizing stream converter: packs FACTOR narrow words into one wide word.
// Define DS_WIDTH_MULTIPLIER_MSB_FIRST_EN to place the first word in the MSBs.
module ds_width_multiplier #(
   parameter int IWIDTH = 8,
   parameter int FACTOR = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [IWIDTH-1:0]        i_dat,
   input  logic                     i_val,
   output logic                     i_rdy,
   output logic [IWIDTH*FACTOR-1:0] o_dat,
   output logic                     o_val,
   input  logic                     o_rdy
);

   localparam int            CW   = (FACTOR > 1) ? $clog2(FACTOR) : 1;
   localparam logic [CW-1:0] LAST = CW'(FACTOR - 1);

   logic [CW-1:0]                   cnt_q, cnt_d;
   logic [FACTOR-2:0][IWIDTH-1:0]   acc_q, acc_d;
   logic [FACTOR-1:0][IWIDTH-1:0]   o_dat_q, o_dat_d;
   logic [FACTOR-1:0][IWIDTH-1:0]   wide;
   logic                            o_val_q, o_val_d;
   logic                            last, in_xfer, out_xfer;

   assign last     = (cnt_q == LAST);
   // Only the final word needs room in the output register.
   assign i_rdy    = ~last | ~o_val_q | o_rdy;
   assign in_xfer  = i_val & i_rdy;
   assign out_xfer = o_val_q & o_rdy;

   genvar k;
   generate
`ifdef DS_WIDTH_MULTIPLIER_MSB_FIRST_EN
      for (k = 0; k < FACTOR-1; k++) begin : g_slot
         assign wide[FACTOR-1-k] = acc_q[k];
      end
      assign wide[0] = i_dat;
`else
      for (k = 0; k < FACTOR-1; k++) begin : g_slot
         assign wide[k] = acc_q[k];
      end
      assign wide[FACTOR-1] = i_dat;
`endif
   endgenerate

   always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      o_dat_d = o_dat_q;
      o_val_d = o_val_q;
      if (out_xfer) o_val_d = 1'b0;
      if (in_xfer) begin
         if (last) begin
            o_dat_d = wide;
            o_val_d = 1'b1;
            cnt_d   = '0;
         end else begin
            for (int j = 0; j < FACTOR-1; j++)
               if (cnt_q == CW'(j)) acc_d[j] = i_dat;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         o_dat_q <= '0;
         o_val_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         o_dat_q <= o_dat_d;
         o_val_q <= o_val_d;
      end
   end

   assign o_dat = o_dat_q;
   assign o_val = o_val_q;

endmodule

// File: doc/ds_width_multiplier.md
# ds_width_multiplier

DataStream upsizing width converter: packs FACTOR consecutive narrow inbound words into one wide outbound word. It is the inverse of the downsizing divider in the same stream library. A stream narrowed for a serial or narrow transport is restored to its original width on the far side. With the default ordering, a divider followed by this block reproduces the original word.

## Interface
- IWIDTH, 8: inbound (narrow) stream width, ≥1.
- FACTOR, 4: outbound-to-inbound width ratio, ≥2; need not be a power of two.
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset: state clears immediately on assertion; release is synchronous to clk by the upstream reset synchroniser.
- i_dat  input  IWIDTH  inbound narrow word.
- i_val  input  1  inbound word valid.
- i_rdy  output  1  block accepts inbound word.
- o_dat  output  IWIDTH*FACTOR  outbound wide word.
- o_val  output  1  outbound word valid.
- o_rdy  input  1  downstream accepts outbound word.

## Operation
- Transfer occurs on a clock edge with val & rdy high on the same side; no other edge changes data state.
- Word counter cnt, width $clog2(FACTOR), counts inbound transfers 0..FACTOR-1 and wraps to 0 after FACTOR-1.
- Accumulator holds FACTOR-1 narrow words. An inbound transfer with cnt<FACTOR-1 writes i_dat into slot cnt.
- An inbound transfer with cnt==FACTOR-1 is the final word. It loads the output register with the accumulator plus i_dat in slot FACTOR-1, sets o_val and wraps cnt to 0.
- Slot k occupies o_dat[(k+1)*IWIDTH-1 : k*IWIDTH], so the first word received lands in the LSBs.
- Output register: o_val clears on an outbound transfer unless a final-word inbound transfer happens on the same edge. In that case it reloads and o_val stays 1.
- i_rdy = (cnt != FACTOR-1) | ~o_val | o_rdy (combinational). Non-final words are always accepted, even while the output is stalled. The final word is accepted only if the output register is free or is draining on that edge.
- o_val, o_dat registered; no combinational path from i_dat/i_val to o_dat/o_val. o_rdy reaches o_val/o_dat only through registers; o_rdy→i_rdy path is combinational.
- o_dat holds its value while o_val=1 & o_rdy=0. After a drain it holds the last value; do not rely on it when o_val=0.
- i_val with i_rdy=0: no state change. The upstream source must hold i_dat stable per the stream rules.

## Timing
- Reset values: o_val=0, o_dat=0, cnt=0, accumulator=0. i_rdy reads 1 while reset is asserted; transfers during reset are discarded.
- Latency: final narrow word accepted at edge N, so o_val=1 with the full word after edge N.
- Throughput: one inbound word per cycle sustained, one outbound word per FACTOR cycles, with no bubbles when o_rdy=1.
- Backpressure: with o_rdy=0 and o_val=1, the block accepts FACTOR-1 further words, then deasserts i_rdy at cnt==FACTOR-1.
- Reset asserted mid-word discards the partial word. After release, the next inbound word is slot 0.
- FACTOR non-power-of-two: cnt wraps explicitly at FACTOR-1; codes ≥FACTOR are unreachable.

## Configuration
- DS_WIDTH_MULTIPLIER_MSB_FIRST_EN defined: slot k maps to o_dat[(FACTOR-k)*IWIDTH-1 : (FACTOR-k-1)*IWIDTH], so the first word received lands in the MSBs.
- Not defined (default): LSB-first mapping as in Operation, the exact inverse of the divider.
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- IWIDTH=8, FACTOR=4, o_rdy=1: i_dat 0x11,0x22,0x33,0x44 on consecutive cycles → one cycle after 0x44, o_val=1 and o_dat=0x44332211 for one cycle; i_rdy stays 1 throughout.
- Same build, o_rdy=0: send 8 words 0x01..0x08 back to back → o_dat=0x04030201 held. 0x05..0x07 are accepted, then i_rdy=0 at 0x08. Raising o_rdy then gives 0x04030201, then 0x08070605.
- Simultaneous events: o_val=1 and o_rdy=1 on the edge the final word arrives → o_val stays 1 and o_dat updates to the new word with no gap or loss.
- Reset asserted asynchronously after 2 of 4 words (0xAA,0xBB) → o_val=0 immediately. After release, 0x01..0x04 → o_dat=0x04030201.
- FACTOR=3, IWIDTH=4: a stream of 0x1..0x6 → 0x321 then 0x654; cnt never exceeds 2.
- With DS_WIDTH_MULTIPLIER_MSB_FIRST_EN, first test stimulus → o_dat=0x11223344.
